// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - shared ALU codes, ALUOp encodings, FSM states and counter sizing
package alu_ctrl_pkg;

    // Base RV32I ALU codes (5-bit form; zero-extended to CTRL_W at the outputs)
    localparam logic [4:0] ALU_ADD   = 5'b00000;
    localparam logic [4:0] ALU_SUB   = 5'b00001;
    localparam logic [4:0] ALU_OR    = 5'b00010;
    localparam logic [4:0] ALU_AND   = 5'b00011;
    localparam logic [4:0] ALU_XOR   = 5'b00100;
    localparam logic [4:0] ALU_SLT   = 5'b00101;
    localparam logic [4:0] ALU_SLTU  = 5'b00110;
    localparam logic [4:0] ALU_SLL   = 5'b00111;
    localparam logic [4:0] ALU_SRL   = 5'b01000;
    localparam logic [4:0] ALU_SRA   = 5'b01001;
    localparam logic [4:0] ALU_PASSB = 5'b01010;

    // M-extension codes are 10<func3>; MUL is the base of that range
    localparam logic [1:0] ALU_MOP_PREFIX = 2'b10;

    // ALUOp encodings from the main decoder
    localparam logic [1:0] ALUOP_LDST   = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_LUI    = 2'b11;

    // Mul/div sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

    // Iteration counter width for a given MD_CYCLES
    function automatic int md_cnt_w(input int md_cycles);
        return $clog2(md_cycles + 1);
    endfunction

endpackage

// File: rtl/alu_ctrl_seq_if.sv
// rtl/alu_ctrl_seq_if.sv - EX-stage decode fields in, ALU code and mul/div sequencing out
//
// master: the pipeline side (drives instruction fields, md_div_zero, flush)
// slave : alu_ctrl_seq (drives ALUControl, stall, md_start, md_step, md_done)
interface alu_ctrl_seq_if #(
    parameter int CTRL_W = 5
);
    logic              valid_in;
    logic [1:0]        ALUOp;
    logic [2:0]        func3;
    logic              OPCode_b5;
    logic              func7_b5;
    logic              func7_b0;
    logic              md_div_zero;
    logic              flush;
    logic [CTRL_W-1:0] ALUControl;
    logic              stall;
    logic              md_start;
    logic              md_step;
    logic              md_done;

    modport master (
        output valid_in, ALUOp, func3, OPCode_b5, func7_b5, func7_b0, md_div_zero, flush,
        input  ALUControl, stall, md_start, md_step, md_done
    );

    modport slave (
        input  valid_in, ALUOp, func3, OPCode_b5, func7_b5, func7_b0, md_div_zero, flush,
        output ALUControl, stall, md_start, md_step, md_done
    );
endinterface

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - combinational ALUOp/func3/func7 to ALU code decode
//
// Ports:
//   ALUOp, func3, OPCode_b5, func7_b5, func7_b0 : instruction fields
//   code   : ALU operation code, zero-extended to CTRL_W
//   is_mop : the fields select an M-extension op (only when M_EXT=1)
module alu_op_decode
    import alu_ctrl_pkg::*;
#(
    parameter int CTRL_W = 5,
    parameter bit M_EXT  = 1'b1
) (
    input  logic [1:0]        ALUOp,
    input  logic [2:0]        func3,
    input  logic              OPCode_b5,
    input  logic              func7_b5,
    input  logic              func7_b0,
    output logic [CTRL_W-1:0] code,
    output logic              is_mop
);

    logic [4:0] code5;

    always_comb begin
        code5  = ALU_ADD;
        is_mop = 1'b0;
        // M-ops take priority over the base R-type decode of the same func3
        if (M_EXT && (ALUOp == ALUOP_RTYPE) && OPCode_b5 && func7_b0) begin
            is_mop = 1'b1;
            code5  = {ALU_MOP_PREFIX, func3};
        end else begin
            case (ALUOp)
                ALUOP_LDST:   code5 = ALU_ADD;
                ALUOP_BRANCH: code5 = ALU_SUB;
                ALUOP_LUI:    code5 = ALU_PASSB;
                default: begin
                    case (func3)
                        // func7_b5 only means SUB for R-type; I-type ADDI reuses that bit as immediate
                        3'b000:  code5 = (OPCode_b5 && func7_b5) ? ALU_SUB : ALU_ADD;
                        3'b001:  code5 = ALU_SLL;
                        3'b010:  code5 = ALU_SLT;
                        3'b011:  code5 = ALU_SLTU;
                        3'b100:  code5 = ALU_XOR;
                        // SRAI carries the same func7_b5 marker, so OPCode_b5 is irrelevant here
                        3'b101:  code5 = func7_b5 ? ALU_SRA : ALU_SRL;
                        3'b110:  code5 = ALU_OR;
                        default: code5 = ALU_AND;
                    endcase
                end
            endcase
        end
    end

    assign code = CTRL_W'(code5);

endmodule

// File: rtl/alu_ctrl_seq.sv
// rtl/alu_ctrl_seq.sv - ALU control decode with iterative mul/div sequencing and stall
//
// Ports:
//   clk   : core clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : alu_ctrl_seq_if.slave
//           in : valid_in, ALUOp, func3, OPCode_b5, func7_b5, func7_b0, md_div_zero, flush
//           out: ALUControl, stall, md_start, md_step, md_done
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int CTRL_W    = 5,
    parameter bit M_EXT     = 1'b1,
    parameter int MD_CYCLES = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_ctrl_seq_if.slave  bus
);

    localparam int CW = md_cnt_w(MD_CYCLES);

    localparam logic [1:0] S_IDLE = 2'(ST_IDLE);
    localparam logic [1:0] S_BUSY = 2'(ST_BUSY);
    localparam logic [1:0] S_DONE = 2'(ST_DONE);

    localparam logic [CW-1:0] CNT_LAST_FULL = CW'(MD_CYCLES - 1);

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CTRL_W-1:0] code_q, code_d;
    logic              dz_q, dz_d;
    logic              start_q, start_d;

    logic [CTRL_W-1:0] dec_code;
    logic              dec_is_mop;
    logic              accept;
    logic [CW-1:0]     cnt_last;

    alu_op_decode #(
        .CTRL_W (CTRL_W),
        .M_EXT  (M_EXT)
    ) u_decode (
        .ALUOp     (bus.ALUOp),
        .func3     (bus.func3),
        .OPCode_b5 (bus.OPCode_b5),
        .func7_b5  (bus.func7_b5),
        .func7_b0  (bus.func7_b0),
        .code      (dec_code),
        .is_mop    (dec_is_mop)
    );

    assign accept = (state_q == S_IDLE) && bus.valid_in && dec_is_mop && !bus.flush;

    // Divides by zero finish after a single iteration; code bit 2 is func3[2], i.e. DIV/DIVU/REM/REMU
    assign cnt_last = (dz_q && code_q[2]) ? '0 : CNT_LAST_FULL;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        dz_d    = dz_q;
        start_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_BUSY;
                    cnt_d   = '0;
                    code_d  = dec_code;
                    dz_d    = bus.md_div_zero;
                    start_d = 1'b1;
                end
            end
            S_BUSY: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == cnt_last) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                // No accept here: the instruction leaving EX this cycle is the one just completed
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            code_q  <= CTRL_W'(ALU_ADD);
            dz_q    <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            dz_q    <= dz_d;
            start_q <= start_d;
        end
    end

    // Outputs are gated with rst_n so the pulses drop the moment reset is asserted,
    // including the combinational accept stall in IDLE.
    assign bus.stall      = rst_n && !bus.flush && (accept || (state_q == S_BUSY));
    assign bus.md_step    = rst_n && (state_q == S_BUSY);
    assign bus.md_start   = rst_n && start_q && (state_q == S_BUSY);
    assign bus.md_done    = rst_n && (state_q == S_DONE) && !bus.flush;
    assign bus.ALUControl = (state_q == S_IDLE) ? dec_code : code_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb/tb_alu_ctrl_seq.sv - directed vector and sequence bench for alu_ctrl_seq
module tb_alu_ctrl_seq;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;
    int   cyc;

    alu_ctrl_seq_if #(.CTRL_W(5)) bus1 ();
    alu_ctrl_seq_if #(.CTRL_W(5)) bus0 ();

    alu_ctrl_seq #(.CTRL_W(5), .M_EXT(1'b1), .MD_CYCLES(32)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    alu_ctrl_seq #(.CTRL_W(5), .M_EXT(1'b0), .MD_CYCLES(32)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0] aluop;
        logic [2:0] f3;
        logic       opb5;
        logic       f7b5;
        logic       f7b0;
        logic [4:0] exp1;
        logic [4:0] exp0;
    } vec_t;

    vec_t vecs[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] aluop, input logic [2:0] f3, input logic opb5,
                         input logic f7b5, input logic f7b0, input logic valid,
                         input logic dz, input logic fl);
        bus1.ALUOp = aluop;  bus0.ALUOp = aluop;
        bus1.func3 = f3;     bus0.func3 = f3;
        bus1.OPCode_b5 = opb5; bus0.OPCode_b5 = opb5;
        bus1.func7_b5 = f7b5;  bus0.func7_b5 = f7b5;
        bus1.func7_b0 = f7b0;  bus0.func7_b0 = f7b0;
        bus1.valid_in = valid;
        bus0.valid_in = 1'b1;
        bus1.md_div_zero = dz; bus0.md_div_zero = dz;
        bus1.flush = fl;       bus0.flush = fl;
    endtask

    task automatic idle_in();
        drive(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Accept an M-op, then check every BUSY cycle, the DONE cycle and the following IDLE cycle
    task automatic run_mop(input string tag, input logic [2:0] f3, input logic dz, input int nbusy);
        logic [4:0] code;
        code = {2'b10, f3};
        @(negedge clk);
        drive(2'b10, f3, 1'b1, 1'b0, 1'b1, 1'b1, dz, 1'b0);
        #1;
        chk({tag, " accept stall"}, bus1.stall, 1'b1);
        chk({tag, " accept start"}, bus1.md_start, 1'b0);
        chk({tag, " accept code"}, bus1.ALUControl, code);
        @(negedge clk);
        idle_in();
        for (int i = 1; i <= nbusy; i++) begin
            #1;
            chk({tag, " busy stall"}, bus1.stall, 1'b1);
            chk({tag, " busy step"}, bus1.md_step, 1'b1);
            chk({tag, " busy start"}, bus1.md_start, (i == 1));
            chk({tag, " busy done"}, bus1.md_done, 1'b0);
            chk({tag, " busy code"}, bus1.ALUControl, code);
            @(negedge clk);
        end
        #1;
        chk({tag, " done pulse"}, bus1.md_done, 1'b1);
        chk({tag, " done stall"}, bus1.stall, 1'b0);
        chk({tag, " done step"}, bus1.md_step, 1'b0);
        chk({tag, " done code"}, bus1.ALUControl, code);
        @(negedge clk);
        #1;
        chk({tag, " after done"}, bus1.md_done, 1'b0);
        chk({tag, " after stall"}, bus1.stall, 1'b0);
        chk({tag, " after code"}, bus1.ALUControl, 5'b00000);
    endtask

    initial begin
        int done_t[2];
        int nd;
        n_cmp  = 0;
        n_fail = 0;
        cyc    = 0;

        //            aluop  f3      opb5  f7b5  f7b0  exp(M_EXT=1) exp(M_EXT=0)
        vecs[0]  = '{2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 5'b00000, 5'b00000};
        vecs[1]  = '{2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 5'b00001, 5'b00001};
        vecs[2]  = '{2'b10, 3'b010, 1'b1, 1'b0, 1'b0, 5'b00101, 5'b00101};
        vecs[3]  = '{2'b10, 3'b110, 1'b1, 1'b0, 1'b0, 5'b00010, 5'b00010};
        vecs[4]  = '{2'b10, 3'b111, 1'b1, 1'b0, 1'b0, 5'b00011, 5'b00011};
        vecs[5]  = '{2'b10, 3'b000, 1'b1, 1'b1, 1'b0, 5'b00001, 5'b00001};
        vecs[6]  = '{2'b10, 3'b000, 1'b0, 1'b1, 1'b0, 5'b00000, 5'b00000};
        vecs[7]  = '{2'b10, 3'b101, 1'b0, 1'b1, 1'b0, 5'b01001, 5'b01001};
        vecs[8]  = '{2'b10, 3'b101, 1'b0, 1'b0, 1'b0, 5'b01000, 5'b01000};
        vecs[9]  = '{2'b10, 3'b011, 1'b0, 1'b0, 1'b0, 5'b00110, 5'b00110};
        vecs[10] = '{2'b11, 3'b000, 1'b0, 1'b0, 1'b0, 5'b01010, 5'b01010};
        vecs[11] = '{2'b10, 3'b001, 1'b1, 1'b0, 1'b0, 5'b00111, 5'b00111};
        vecs[12] = '{2'b10, 3'b100, 1'b1, 1'b0, 1'b0, 5'b00100, 5'b00100};
        vecs[13] = '{2'b10, 3'b000, 1'b1, 1'b0, 1'b1, 5'b10000, 5'b00000};
        vecs[14] = '{2'b10, 3'b101, 1'b1, 1'b1, 1'b1, 5'b10101, 5'b01001};
        vecs[15] = '{2'b10, 3'b111, 1'b1, 1'b0, 1'b1, 5'b10111, 5'b00011};
        vecs[16] = '{2'b10, 3'b000, 1'b0, 1'b1, 1'b1, 5'b00000, 5'b00000};
        vecs[17] = '{2'b00, 3'b111, 1'b1, 1'b1, 1'b1, 5'b00000, 5'b00000};
        vecs[18] = '{2'b01, 3'b010, 1'b1, 1'b0, 1'b1, 5'b00001, 5'b00001};

        // Reset: a valid MUL presented while reset is held must not stall or pulse
        rst_n = 1'b0;
        drive(2'b10, 3'b000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        chk("rst stall", bus1.stall, 1'b0);
        chk("rst start", bus1.md_start, 1'b0);
        chk("rst step", bus1.md_step, 1'b0);
        chk("rst done", bus1.md_done, 1'b0);
        chk("rst code", bus1.ALUControl, 5'b10000);
        @(negedge clk);
        idle_in();
        rst_n = 1'b1;

        // Decode table, valid_in=0 on the M_EXT=1 instance, valid_in=1 on the M_EXT=0 instance
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            drive(vecs[i].aluop, vecs[i].f3, vecs[i].opb5, vecs[i].f7b5, vecs[i].f7b0,
                  1'b0, 1'b0, 1'b0);
            #1;
            chk($sformatf("vec%0d code", i), bus1.ALUControl, vecs[i].exp1);
            chk($sformatf("vec%0d stall", i), bus1.stall, 1'b0);
            chk($sformatf("vec%0d code mext0", i), bus0.ALUControl, vecs[i].exp0);
            chk($sformatf("vec%0d stall mext0", i), bus0.stall, 1'b0);
            chk($sformatf("vec%0d step mext0", i), bus0.md_step, 1'b0);
        end
        @(negedge clk);
        idle_in();

        run_mop("mul", 3'b000, 1'b0, 32);
        run_mop("divu_dz", 3'b101, 1'b1, 1);
        run_mop("rem", 3'b110, 1'b0, 32);
        run_mop("mulh_dz", 3'b001, 1'b1, 32);

        // flush in IDLE suppresses the accept
        @(negedge clk);
        drive(2'b10, 3'b000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        #1;
        chk("idle flush stall", bus1.stall, 1'b0);
        @(negedge clk);
        idle_in();
        #1;
        chk("idle flush step", bus1.md_step, 1'b0);

        // flush at BUSY count 10
        @(negedge clk);
        drive(2'b10, 3'b000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        idle_in();
        for (int i = 0; i < 10; i++) @(negedge clk);
        bus1.flush = 1'b1;
        #1;
        chk("busy flush stall", bus1.stall, 1'b0);
        @(negedge clk);
        bus1.flush = 1'b0;
        #1;
        chk("post flush step", bus1.md_step, 1'b0);
        chk("post flush stall", bus1.stall, 1'b0);
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (bus1.md_done) nd++;
        end
        chk("post flush no done", nd, 0);

        // flush in DONE swallows md_done
        @(negedge clk);
        drive(2'b10, 3'b100, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        idle_in();
        @(negedge clk);
        bus1.flush = 1'b1;
        #1;
        chk("done flush done", bus1.md_done, 1'b0);
        chk("done flush stall", bus1.stall, 1'b0);
        @(negedge clk);
        bus1.flush = 1'b0;

        // async reset at BUSY count 5
        @(negedge clk);
        drive(2'b10, 3'b000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        idle_in();
        for (int i = 0; i < 5; i++) @(negedge clk);
        #1;
        chk("pre rst step", bus1.md_step, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid rst stall", bus1.stall, 1'b0);
        chk("mid rst step", bus1.md_step, 1'b0);
        chk("mid rst done", bus1.md_done, 1'b0);
        chk("mid rst start", bus1.md_start, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post rst step", bus1.md_step, 1'b0);
        chk("post rst code", bus1.ALUControl, 5'b00000);
        run_mop("mul after rst", 3'b000, 1'b0, 32);

        // back-to-back MULs: instruction held valid; the second is accepted right after DONE
        @(negedge clk);
        drive(2'b10, 3'b000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        nd = 0;
        for (int i = 0; i < 100 && nd < 2; i++) begin
            #1;
            if (bus1.md_done) begin
                done_t[nd] = cyc;
                nd++;
            end
            @(negedge clk);
        end
        idle_in();
        chk("b2b done count", nd, 2);
        if (nd == 2) chk("b2b spacing", done_t[1] - done_t[0], 34);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_seq.md
Name: alu_ctrl_seq

Overview:
Next-generation ALU control for the RV32 core. It decodes ALUOp/func3/func7 into a widened ALUControl covering full RV32I ALU ops plus optional RV32M. For M-extension ops it sequences an external iterative mul/div datapath: it asserts a pipeline stall, counts iterations, and pulses completion. It sits in EX, beside the main decoder and in front of the ALU and mul/div unit.

Parameters:
CTRL_W, 5, ALUControl width; must be at least 5.
M_EXT, 1, 1 enables M-op decode and sequencing; 0 ignores func7_b0, so M encodings decode as base RV32I.
MD_CYCLES, 32, number of BUSY iterations for a normal mul/div; must be at least 1.

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
valid_in  in  1  EX stage holds a valid instruction
ALUOp  in  2  00 load/store, 01 branch, 10 R/I-type, 11 LUI pass-B
func3  in  3  instruction func3
OPCode_b5  in  1  opcode bit 5 (1 = R-type)
func7_b5  in  1  func7 bit 5
func7_b0  in  1  func7 bit 0 (M-extension select)
md_div_zero  in  1  divisor is zero, from datapath, sampled at accept
flush  in  1  kill the in-flight M-op
ALUControl  out  CTRL_W  ALU operation code
stall  out  1  hold IF/ID/EX
md_start  out  1  one-cycle start pulse to mul/div unit
md_step  out  1  mul/div iteration enable
md_done  out  1  one-cycle result-valid pulse

Behaviour:
- Codes, zero-extended to CTRL_W. Legacy values are unchanged.
  - Base ops: ADD 00000, SUB 00001, OR 00010, AND 00011, XOR 00100, SLT 00101, SLTU 00110, SLL 00111, SRL 01000, SRA 01001, PASSB 01010.
  - M ops: MUL..REMU 10000..10111, with the low 3 bits equal to func3.
- Decode (combinational in IDLE):
  - ALUOp 00 gives ADD; 01 gives SUB; 11 gives PASSB.
  - ALUOp 10, func3 000: SUB only when OPCode_b5 and func7_b5 are both 1; otherwise ADD.
  - ALUOp 10, func3 101: SRA if func7_b5 is 1, else SRL, independent of OPCode_b5.
  - ALUOp 10, func3 001/010/011/100/110/111 give SLL/SLT/SLTU/XOR/OR/AND.
  - M-op when M_EXT=1, ALUOp=10, OPCode_b5=1 and func7_b0=1; this overrides the rules above.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: if valid_in and an M-op is decoded, latch the code and md_div_zero, drive stall=1 combinationally, and go to BUSY. Otherwise stall=0.
  - BUSY: stall=1, md_step=1. md_start=1 in the first BUSY cycle only (registered). The counter goes 0..limit-1, where limit = 1 if the latched div_zero is set and the op is DIV/DIVU/REM/REMU, else MD_CYCLES. When count reaches limit-1, go to DONE.
  - DONE: stall=0, md_done=1 for one cycle; the pipeline advances this cycle. Next state is always IDLE; no new accept is evaluated in DONE.
- ALUControl is driven from the latched code in BUSY and DONE, and from decode in IDLE.
- Latency, normal op accepted at cycle T: BUSY spans T+1..T+MD_CYCLES, DONE is at T+MD_CYCLES+1. Stall is high for MD_CYCLES+1 cycles.
- Latency, divide-by-zero: BUSY at T+1, DONE at T+2.
- flush in BUSY or DONE:
  - next state IDLE, counter cleared, no md_done;
  - stall is forced to 0 in the flush cycle.
- flush in IDLE: the accept is suppressed.
- Back-to-back M-ops: DONE→IDLE, then the next instruction is accepted in its IDLE cycle. There is no bubble beyond the DONE cycle.
- Reset (asynchronous, any state):
  - state IDLE, counter 0, latched code ADD;
  - md_start, md_step, md_done, stall all 0 while rst_n is low;
  - ALUControl is the combinational decode.
- Non-M ops never affect the FSM.

Decomposition:
- Package alu_ctrl_pkg holds:
  - ALU code localparams;
  - ALUOp encodings;
  - the FSM state enum;
  - the counter width, $clog2(MD_CYCLES+1).
- Sub-module alu_op_decode: pure combinational decode of the fields into the code and an is_mop flag. The FSM, counter and latching live in the top.

Test Plan:
- Legacy table, valid_in=0: ALUOp 00 gives 00000; 01 gives 00001; 10/010 gives 00101; 10/110 gives 00010; 10/111 gives 00011; 10/000 with OPCode_b5=1, func7_b5=1 gives 00001; 10/000 with OPCode_b5=0, func7_b5=1 gives 00000.
- Shifts and new ops: I-type 101 with func7_b5=1 gives 01001; with func7_b5=0 gives 01000; 011 gives 00110; ALUOp 11 gives 01010.
- MUL, MD_CYCLES=32: accept at T. stall is 1 for T..T+32; md_start only at T+1; md_step is high for 32 cycles; md_done=1 and stall=0 at T+33.
- DIVU with md_div_zero=1: stall at T and T+1; md_done at T+2. REM with md_div_zero=0 takes the full 32 cycles.
- flush at BUSY count 10: stall=0 that cycle, state IDLE next, md_done never asserted. rst_n pulled low at count 5: all pulses drop immediately and the FSM restarts in IDLE.
- M_EXT=0: func7_b0=1, R-type, func3 000 gives 00000 with stall=0. Two consecutive MULs (M_EXT=1) produce two md_done pulses 34 cycles apart.
